// File: rtl/armleocpu_alu_issue.sv
// armleocpu_alu_issue: issue-side front end of the integer ALU.
// Decodes OP / OP-IMM instruction words and queues them in a two-entry
// registered buffer between fetch and execute. Encodings the ALU cannot
// execute are marked illegal at issue time and still travel down the pipe.
// Optional feature macro: ARMLEOCPU_ALU_ISSUE_MULDIV_EN (OP funct7=0000001
// encodings become legal when defined).
module armleocpu_alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_is_op,
    output logic        out_is_op_imm,
    output logic [4:0]  out_shamt,
    output logic [6:0]  out_funct7,
    output logic [2:0]  out_funct3,
    output logic [31:0] out_simm12,
    output logic [4:0]  out_rs1_addr,
    output logic [4:0]  out_rs2_addr,
    output logic [4:0]  out_rd_addr,
    output logic [31:0] out_pc,
    output logic        out_illegal
);

    typedef struct packed {
        logic        is_op;
        logic        is_op_imm;
        logic [4:0]  shamt;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [31:0] simm12;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        logic        illegal;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

`ifdef ARMLEOCPU_ALU_ISSUE_MULDIV_EN
    localparam logic MULDIV_OK = 1'b1;
`else
    localparam logic MULDIV_OK = 1'b0;
`endif

    entry_t     dec;
    entry_t     mem [2];
    entry_t     head;
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       push;
    logic       pop;

    // Combinational decode of the incoming word, including legality
    always_comb begin
        dec           = '0;
        dec.is_op     = (in_instr[6:0] == OPC_OP);
        dec.is_op_imm = (in_instr[6:0] == OPC_OP_IMM);
        dec.shamt     = in_instr[24:20];
        dec.funct7    = in_instr[31:25];
        dec.funct3    = in_instr[14:12];
        dec.simm12    = {{20{in_instr[31]}}, in_instr[31:20]};
        dec.rs1_addr  = in_instr[19:15];
        dec.rs2_addr  = in_instr[24:20];
        dec.rd_addr   = in_instr[11:7];
        dec.pc        = in_pc;
        dec.illegal   = 1'b0;
        if (!dec.is_op && !dec.is_op_imm) begin
            dec.illegal = 1'b1;
        end else if (dec.is_op_imm) begin
            // Only the shift forms constrain funct7
            if (dec.funct3 == 3'b001 && dec.funct7 != F7_ZERO)
                dec.illegal = 1'b1;
            if (dec.funct3 == 3'b101 && dec.funct7 != F7_ZERO && dec.funct7 != F7_ALT)
                dec.illegal = 1'b1;
        end else begin
            if (dec.funct7 == F7_ALT && dec.funct3 != 3'b000 && dec.funct3 != 3'b101)
                dec.illegal = 1'b1;
            if (dec.funct7 != F7_ZERO && dec.funct7 != F7_ALT && dec.funct7 != F7_MULDIV)
                dec.illegal = 1'b1;
            if (dec.funct7 == F7_MULDIV && !MULDIV_OK)
                dec.illegal = 1'b1;
        end
    end

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointer and occupancy bookkeeping; flush wins over push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so data outputs start at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= dec;
        end
    end

    assign head          = mem[rd_ptr];
    assign out_is_op     = head.is_op;
    assign out_is_op_imm = head.is_op_imm;
    assign out_shamt     = head.shamt;
    assign out_funct7    = head.funct7;
    assign out_funct3    = head.funct3;
    assign out_simm12    = head.simm12;
    assign out_rs1_addr  = head.rs1_addr;
    assign out_rs2_addr  = head.rs2_addr;
    assign out_rd_addr   = head.rd_addr;
    assign out_pc        = head.pc;
    assign out_illegal   = head.illegal;

endmodule

// File: doc/armleocpu_alu_issue.md
# armleocpu_alu_issue

Issue-side front end of the integer ALU. It accepts fetched instruction words through a valid/ready handshake and decodes the OP and OP-IMM fields the ALU consumes (is_op, is_op_imm, shamt, funct7, funct3, simm12), along with register addresses and PC. Decoded entries sit in a two-entry registered buffer that decouples fetch from execute. Encodings the ALU cannot execute are flagged at issue time, so execute never depends on the ALU's combinational illegal path.

## Interface
Parameters: none.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  discard all buffered entries and any same-cycle input
- in_valid  input  1  instruction word valid
- in_ready  output  1  buffer can accept an entry this cycle
- in_instr  input  32  raw instruction word
- in_pc  input  32  PC of in_instr
- out_valid  output  1  head entry valid
- out_ready  input  1  execute consumes head entry this cycle
- out_is_op  output  1  opcode 0110011
- out_is_op_imm  output  1  opcode 0010011
- out_shamt  output  5  instr[24:20]
- out_funct7  output  7  instr[31:25]
- out_funct3  output  3  instr[14:12]
- out_simm12  output  32  instr[31:20], sign-extended
- out_rs1_addr, out_rs2_addr, out_rd_addr  output  5 each  instr[19:15], [24:20], [11:7]
- out_pc  output  32  PC of the head entry
- out_illegal  output  1  head entry is not executable by the ALU

## Operation
- Decode is combinational on in_instr. Decoded fields are written into the buffer when in_valid && in_ready.
- Buffer: 2 entries, write pointer, read pointer, 2-bit count. in_ready = (count != 2). The full state is registered and does not depend on out_ready.
- Outputs always show the head entry. out_valid = (count != 0).
- Pop happens on out_valid && out_ready. Push and pop in the same cycle leave count unchanged. Pointers are 1 bit wide and wrap naturally.
- Illegal rules; the entry is still issued with out_illegal = 1:
  - Opcode other than 0010011/0110011: is_op = is_op_imm = 0.
  - OP-IMM, funct3 = 001, funct7 != 0000000.
  - OP-IMM, funct3 = 101, funct7 not in {0000000, 0100000}.
  - OP with funct7 0100000 and funct3 not in {000, 101}.
  - OP with funct7 not in {0000000, 0100000, 0000001}.
  - OP with funct7 0000001 when the muldiv feature is compiled out.
- Flush has priority over push and pop: count and pointers are cleared at the next edge.
- Contents of an empty buffer are don't-care, but they must not cause X on out_valid.

## Timing
- Reset values:
  - out_valid = 0, count = 0, pointers = 0, in_ready = 1.
  - All data outputs = 0.
- Latency: an entry accepted at edge N shows out_valid = 1 after edge N. Minimum in-to-out latency is 1 cycle; throughput is 1 entry per cycle.
- Full with out_ready = 1: in_ready is 0 in that cycle, so a push cannot happen. Count drops to 1 and in_ready rises the next cycle.
- Empty: push only, no bypass to the outputs.
- Reset asserted mid-operation clears the buffer immediately; in-flight entries are lost.
- out_* must hold stable while out_valid && !out_ready.

## Configuration
- ARMLEOCPU_ALU_ISSUE_MULDIV_EN:
  - Defined: OP with funct7 = 0000001 (all funct3) is legal, out_illegal = 0.
  - Undefined: these encodings issue with out_illegal = 1 and all fields decoded normally.

## Test plan
- Reset, then push 0xFFF10093 (addi x1,x2,-1) with pc 0x100 -> next cycle:
  - out_valid = 1, is_op_imm = 1, funct3 = 0, rs1 = 2, rd = 1
  - simm12 = 0xFFFFFFFF, pc = 0x100, illegal = 0.
- Push 0x40335293 (srai x5,x6,3) -> funct7 = 0x20, shamt = 3, funct3 = 5, illegal = 0.
- Push 0x022081B3 (mul x3,x1,x2) -> with MULDIV_EN illegal = 0; without it illegal = 1, funct7 = 0x01.
- Push 0x00002003 (load) -> illegal = 1, is_op = is_op_imm = 0.
- Hold out_ready = 0 and push 3 words back to back:
  - in_ready falls after 2 accepts and the head stays stable.
  - Raise out_ready: entries drain in order, and in_ready returns to 1 the cycle after the first pop.
- Fill 2 entries, assert flush together with in_valid -> next cycle out_valid = 0 and count = 0; the flushed input is not captured.
